serial_tx_autoinv: RTL and testbench

//  Framed serial transmitter that sits directly upstream of the differential output pad.

---
 rtl/serial_tx_pkg.sv | 12 +
 rtl/serial_tx_shifter.sv | 40 ++++
 rtl/serial_tx_autoinv.sv | 95 +++++++++
 tb/tb_serial_tx_autoinv.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared state encoding and defaults for the framed serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'hA5;

endpackage

// File: rtl/serial_tx_shifter.sv
// Load/shift register with bit counter for one frame's data bits, MSB first.
module serial_tx_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             msb_o,
    output logic             last_o,
    output logic             near_last_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= dat_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            // Hold at the last bit so the counter never wraps.
            if (!last_o) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign msb_o       = shreg_q[WIDTH-1];
    assign last_o      = (cnt_q == CW'(WIDTH - 1));
    assign near_last_o = (cnt_q == CW'(WIDTH - 2));

endmodule

// File: rtl/serial_tx_autoinv.sv
// Framed serial transmitter (start bit + WIDTH data bits MSB first) with output polarity
// inversion. Define SERIAL_TX_TRAIN_EN to add the train_i port and training frames.
module serial_tx_autoinv
    import serial_tx_pkg::*;
#(
    parameter int unsigned      WIDTH         = 8,
    parameter logic             INV           = 1'b0,
    parameter logic             IDLE_BIT      = 1'b0
`ifdef SERIAL_TX_TRAIN_EN
    ,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_DEFAULT)
`endif
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             ser_o
`ifdef SERIAL_TX_TRAIN_EN
    ,
    input  logic             train_i
`endif
);

    state_e           state_q, state_d;
    logic             slot, xfer_user, xfer_train, load, shift;
    logic             ready_d, ser_d;
    logic             msb, last, near_last;
    logic [WIDTH-1:0] load_dat;

    serial_tx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .load_i      (load),
        .shift_i     (shift),
        .dat_i       (load_dat),
        .msb_o       (msb),
        .last_o      (last),
        .near_last_o (near_last)
    );

    always_comb begin
        slot      = (state_q == ST_IDLE) || ((state_q == ST_DATA) && last);
        xfer_user = valid_i && ready_o;
`ifdef SERIAL_TX_TRAIN_EN
        // A word already offered via ready_o is honoured so it is never dropped.
        xfer_train = slot && train_i && !xfer_user;
        load_dat   = xfer_train ? TRAIN_PATTERN : dat_i;
`else
        xfer_train = 1'b0;
        load_dat   = dat_i;
`endif
        load  = xfer_user || xfer_train;
        shift = (state_q == ST_DATA) && !load;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = load ? ST_START : ST_IDLE;
            ST_START: state_d = ST_DATA;
            ST_DATA:  if (last) state_d = load ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || ((state_q == ST_DATA) && near_last);
`ifdef SERIAL_TX_TRAIN_EN
        ready_d = ready_d && !train_i;
`endif

        // Serial output follows the current state, one cycle behind the transfer edge.
        unique case (state_q)
            ST_START: ser_d = ~IDLE_BIT ^ INV;
            ST_DATA:  ser_d = msb ^ INV;
            default:  ser_d = IDLE_BIT ^ INV;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            ser_o   <= IDLE_BIT ^ INV;
        end else begin
            state_q <= state_d;
            ready_o <= ready_d;
            busy_o  <= (state_d != ST_IDLE);
            ser_o   <= ser_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_autoinv.sv
// Directed bench for serial_tx_autoinv: one INV=0 and one INV=1 instance on shared inputs.
module tb_serial_tx_autoinv;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] dat;
    logic       valid;
    logic       ready0, busy0, ser0;
    logic       ready1, busy1, ser1;
`ifdef SERIAL_TX_TRAIN_EN
    logic       train;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx_autoinv #(
        .WIDTH    (8),
        .INV      (1'b0),
        .IDLE_BIT (1'b0)
    ) dut0 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .dat_i   (dat),
        .valid_i (valid),
        .ready_o (ready0),
        .busy_o  (busy0),
        .ser_o   (ser0)
`ifdef SERIAL_TX_TRAIN_EN
        ,
        .train_i (train)
`endif
    );

    serial_tx_autoinv #(
        .WIDTH    (8),
        .INV      (1'b1),
        .IDLE_BIT (1'b0)
    ) dut1 (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .dat_i   (dat),
        .valid_i (valid),
        .ready_o (ready1),
        .busy_o  (busy1),
        .ser_o   (ser1)
`ifdef SERIAL_TX_TRAIN_EN
        ,
        .train_i (train)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word from idle and checks the full frame on both instances.
    task automatic run_frame(input string tag, input logic [7:0] word);
        logic e, ne, er, eb;
        dat   = word;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        dat   = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (i == 1)                e = 1'b1;
            else if (i >= 2 && i <= 9) e = word[9-i];
            else                       e = 1'b0;
            ne = ~e;
            er = (i >= 8);
            eb = (i <= 8);
            check($sformatf("%s_ser0[%0d]", tag, i), ser0, e);
            check($sformatf("%s_ser1[%0d]", tag, i), ser1, ne);
            check($sformatf("%s_ready[%0d]", tag, i), ready0, er);
            check($sformatf("%s_busy[%0d]", tag, i), busy0, eb);
            check($sformatf("%s_busy1[%0d]", tag, i), busy1, eb);
            tick;
        end
    endtask

    initial begin
        logic       e, er, eb;
        logic [7:0] w1, w2;

        rstn  = 1'b0;
        valid = 1'b0;
        dat   = 8'h00;
`ifdef SERIAL_TX_TRAIN_EN
        train = 1'b0;
`endif

        // Reset held for five clocks.
        repeat (5) tick;
        check("rst_ready0", ready0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ser0", ser0, 1'b0);
        check("rst_ready1", ready1, 1'b0);
        check("rst_ser1", ser1, 1'b1);
        rstn = 1'b1;
        check("rel_ready_pre", ready0, 1'b0);
        tick;
        check("rel_ready_post", ready0, 1'b1);
        check("rel_ready1_post", ready1, 1'b1);

        // Single frame, both polarities.
        run_frame("c3", 8'hC3);

        // Back-to-back: 01 then 80 with valid held high.
        w1    = 8'h01;
        w2    = 8'h80;
        dat   = w1;
        valid = 1'b1;
        tick;
        dat = w2;
        for (int j = 0; j < 21; j++) begin
            if (j == 1 || j == 10)       e = 1'b1;
            else if (j >= 2 && j <= 9)   e = w1[9-j];
            else if (j >= 11 && j <= 18) e = w2[18-j];
            else                         e = 1'b0;
            eb = (j <= 17);
            er = (j == 8) || (j >= 17);
            check($sformatf("b2b_ser[%0d]", j), ser0, e);
            check($sformatf("b2b_busy[%0d]", j), busy0, eb);
            check($sformatf("b2b_ready[%0d]", j), ready0, er);
            tick;
            if (j == 8) valid = 1'b0;
        end

        // Asynchronous reset in the middle of data bit 4 of FF.
        dat   = 8'hFF;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        repeat (5) tick;
        check("mid_ser0_bit4", ser0, 1'b1);
        check("mid_ser1_bit4", ser1, 1'b0);
        check("mid_busy", busy0, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("async_ser0", ser0, 1'b0);
        check("async_ser1", ser1, 1'b1);
        check("async_busy", busy0, 1'b0);
        check("async_ready", ready0, 1'b0);
        tick;
        rstn = 1'b1;
        check("rerel_ready_pre", ready0, 1'b0);
        tick;
        check("rerel_ready_post", ready0, 1'b1);
        run_frame("5a", 8'h5A);

`ifdef SERIAL_TX_TRAIN_EN
        // Training frames block the pending user word until train drops mid-frame.
        w1    = 8'hA5;
        w2    = 8'h3C;
        train = 1'b1;
        tick;
        valid = 1'b1;
        dat   = w2;
        for (int j = 0; j < 30; j++) begin
            if (j == 1 || j == 10 || j == 19) e = 1'b1;
            else if (j >= 2 && j <= 9)        e = w1[9-j];
            else if (j >= 11 && j <= 18)      e = w1[18-j];
            else if (j >= 20 && j <= 27)      e = w2[27-j];
            else                              e = 1'b0;
            er = (j == 17) || (j >= 26);
            check($sformatf("train_ser[%0d]", j), ser0, e);
            check($sformatf("train_ready[%0d]", j), ready0, er);
            if (j == 14) train = 1'b0;
            tick;
            if (j == 17) valid = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
